// File: rtl/bist_scan_controller.sv
// Built-in self-test harness: an LFSR feeds a 2N-bit scan chain wrapped around an
// NxN multiplier, and a MISR compacts the chain output. Supports manual and auto runs.
module bist_scan_controller #(
  parameter int N = 4,
  parameter int NUM_PATTERNS = 16,
  parameter logic [2*N-1:0] SEED = 8'hBD,
  parameter logic [2*N-1:0] TAPS = 8'hB8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic           start,
  input  logic           scan_en,
  input  logic [2*N-1:0] golden_sig,
  output logic           scan_in,
  output logic           scan_out,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*N-1:0] signature
);

  // state     | meaning
  // S_IDLE    | manual shift/capture when mode = 0; waits for start when mode = 1
  // S_SHIFT   | auto run: shift one pattern into the chain
  // S_CAPTURE | auto run: one capture cycle through the multiplier
  // S_UNLOAD  | auto run: shift the last response out into the MISR
  // S_DONE    | auto run finished; pass tracks misr == golden_sig
  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_UNLOAD,
    S_DONE
  } state_e;

  localparam int L  = 2 * N;
  localparam int BW = $clog2(L);
  localparam int PW = $clog2(NUM_PATTERNS + 1);

  state_e          state_q, state_d;
  logic [L-1:0]    lfsr_q, lfsr_d;
  logic [L-1:0]    chain_q, chain_d;
  logic [L-1:0]    misr_q, misr_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]   pat_left_q, pat_left_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic [L-1:0]    lfsr_shift;
  logic [L-1:0]    chain_shift;
  logic [L-1:0]    misr_shift;
  logic [L-1:0]    chain_capture;
  logic            do_shift;
  logic            do_capture;
  logic            do_load;

  assign lfsr_shift    = {lfsr_q[L-2:0], ^(lfsr_q & TAPS)};
  assign chain_shift   = {chain_q[L-2:0], lfsr_q[L-1]};
  assign misr_shift    = {misr_q[L-2:0], 1'b0}
                       ^ (misr_q[L-1] ? TAPS : {L{1'b0}})
                       ^ {{(L-1){1'b0}}, chain_q[L-1]};
  // Operands are zero-extended so the full 2N-bit product is kept.
  assign chain_capture = {{N{1'b0}}, chain_q[L-1:N]} * {{N{1'b0}}, chain_q[N-1:0]};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    pat_left_d = pat_left_q;
    do_shift   = 1'b0;
    do_capture = 1'b0;
    do_load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mode) begin
          if (start) begin
            do_load = 1'b1;
            state_d = S_SHIFT;
          end
        end else if (scan_en) begin
          do_shift = 1'b1;
        end else begin
          do_capture = 1'b1;
        end
      end
      S_SHIFT: begin
        do_shift = 1'b1;
        if (bit_cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      S_CAPTURE: begin
        do_capture = 1'b1;
        bit_cnt_d  = BW'(L - 1);
        if (pat_left_q == PW'(1)) begin
          state_d = S_UNLOAD;
        end else begin
          pat_left_d = pat_left_q - 1'b1;
          state_d    = S_SHIFT;
        end
      end
      S_UNLOAD: begin
        do_shift = 1'b1;
        if (bit_cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          if (mode) begin
            do_load = 1'b1;
            state_d = S_SHIFT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    lfsr_d  = lfsr_q;
    chain_d = chain_q;
    misr_d  = misr_q;
    if (do_load) begin
      lfsr_d     = SEED;
      chain_d    = '0;
      misr_d     = '0;
      bit_cnt_d  = BW'(L - 1);
      pat_left_d = PW'(NUM_PATTERNS);
    end else if (do_shift) begin
      lfsr_d  = lfsr_shift;
      chain_d = chain_shift;
      misr_d  = misr_shift;
    end else if (do_capture) begin
      chain_d = chain_capture;
    end

    // Compare against the post-update MISR so pass is valid on the DONE entry cycle.
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (misr_d == golden_sig);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      chain_q    <= '0;
      misr_q     <= '0;
      bit_cnt_q  <= '0;
      pat_left_q <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      chain_q    <= chain_d;
      misr_q     <= misr_d;
      bit_cnt_q  <= bit_cnt_d;
      pat_left_q <= pat_left_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign scan_in   = lfsr_q[L-1];
  assign scan_out  = chain_q[L-1];
  assign busy      = (state_q == S_SHIFT) || (state_q == S_CAPTURE) || (state_q == S_UNLOAD);
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr_q;

endmodule

// File: tb/tb_bist_scan_controller.sv
// Bench for bist_scan_controller: fixed manual vectors, random manual traffic against an
// arithmetic reference model, and auto-run corner sequences.
module tb_bist_scan_controller;
  localparam logic [7:0] SEED = 8'hBD;
  localparam logic [7:0] TAPS = 8'hB8;
  localparam int NP = 16;
  localparam int RUN_CYCLES = NP * 9 + 8;

  logic       clk = 1'b0;
  logic       rst, mode, start, scan_en;
  logic [7:0] golden_sig;
  logic       scan_in, scan_out, busy, done, pass;
  logic [7:0] signature;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_lfsr, m_chain, m_misr;
  logic [7:0] sig_ref;

  typedef struct {
    logic se;
    logic exp_in;
    logic exp_out;
  } vec_t;
  vec_t tbl[17];

  bist_scan_controller #(.N(4), .NUM_PATTERNS(NP), .SEED(SEED), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .scan_en(scan_en),
    .golden_sig(golden_sig), .scan_in(scan_in), .scan_out(scan_out),
    .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic on the register values.
  function automatic logic [7:0] nx_lfsr(input logic [7:0] l);
    int v;
    v = (int'(l) * 2 + $countones(l & TAPS) % 2) % 256;
    return v[7:0];
  endfunction

  function automatic logic [7:0] nx_chain(input logic [7:0] c, input logic bit_in);
    int v;
    v = (int'(c) * 2 + int'(bit_in)) % 256;
    return v[7:0];
  endfunction

  function automatic logic [7:0] nx_misr(input logic [7:0] m, input logic bit_in);
    int v;
    v = (int'(m) * 2) % 256;
    if (m >= 8'd128) v = v ^ int'(TAPS);
    v = v ^ int'(bit_in);
    return v[7:0];
  endfunction

  function automatic logic [7:0] cap(input logic [7:0] c);
    int v;
    v = (int'(c) / 16) * (int'(c) % 16);
    return v[7:0];
  endfunction

  task automatic m_shift();
    logic [7:0] l, c, m;
    l = m_lfsr; c = m_chain; m = m_misr;
    m_lfsr  = nx_lfsr(l);
    m_chain = nx_chain(c, l[7]);
    m_misr  = nx_misr(m, c[7]);
  endtask

  function automatic logic [7:0] auto_sig();
    logic [7:0] l, c, m, lo, co;
    l = SEED; c = 8'h00; m = 8'h00;
    for (int p = 0; p <= NP; p++) begin
      for (int b = 0; b < 8; b++) begin
        lo = l; co = c;
        l = nx_lfsr(lo);
        c = nx_chain(co, lo[7]);
        m = nx_misr(m, co[7]);
      end
      if (p < NP) c = cap(c);
    end
    return m;
  endfunction

  task automatic run_auto(input string tag, input logic [7:0] g, input bit disturb);
    int cnt;
    golden_sig = g;
    mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_done_clr"}, done, 1'b0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      if (disturb) begin
        start   = (cnt == 40 || cnt == 41);
        mode    = (cnt >= 30 && cnt < 100) ? 1'($urandom_range(1)) : 1'b1;
        scan_en = 1'($urandom_range(1));
      end
      cnt++;
      tick();
    end
    start = 1'b0;
    mode  = 1'b1;
    check({tag, "_busy_cycles"}, cnt, RUN_CYCLES);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_sig"}, signature, sig_ref);
    check({tag, "_pass"}, pass, (g == sig_ref));
  endtask

  initial begin
    logic [7:0] a, b, c;
    a = 8'hBD; b = 8'h8F; c = 8'h74;
    for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, a[7-i], 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) tbl[9+i] = '{1'b1, c[7-i], b[7-i]};

    sig_ref = auto_sig();
    rst = 1'b1; mode = 1'b0; start = 1'b0; scan_en = 1'b0; golden_sig = 8'h00;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_sig", signature, 8'h00);
    check("rst_scan_in", scan_in, 1'b1);
    rst = 1'b0;

    // Manual shift of the seed, one capture (11*13), then shift the product out.
    for (int i = 0; i < 17; i++) begin
      scan_en = tbl[i].se;
      check($sformatf("tbl%0d_scan_in", i), scan_in, tbl[i].exp_in);
      check($sformatf("tbl%0d_scan_out", i), scan_out, tbl[i].exp_out);
      tick();
    end
    check("tbl_chain_after", scan_out, 1'b0);
    check("tbl_signature", signature, 8'h8F);

    // Random manual traffic; start must be ignored in manual mode.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_lfsr = SEED; m_chain = 8'h00; m_misr = 8'h00;
    for (int i = 0; i < 200; i++) begin
      scan_en = 1'($urandom_range(1));
      start   = 1'($urandom_range(1));
      check("rnd_scan_in", scan_in, m_lfsr[7]);
      check("rnd_scan_out", scan_out, m_chain[7]);
      check("rnd_sig", signature, m_misr);
      check("rnd_busy", busy, 1'b0);
      tick();
      if (scan_en) m_shift();
      else m_chain = cap(m_chain);
    end
    start = 1'b0;

    run_auto("run1", 8'h00, 1'b0);

    // scan_en and mode wiggle in DONE without start: nothing moves.
    for (int i = 0; i < 6; i++) begin
      scan_en = 1'($urandom_range(1));
      mode    = 1'(i % 2);
      tick();
      check("done_hold_sig", signature, sig_ref);
      check("done_hold_done", done, 1'b1);
    end
    mode = 1'b1;

    run_auto("run2", sig_ref, 1'b1);
    golden_sig = sig_ref ^ 8'h01;
    tick();
    check("refresh_pass", pass, 1'b0);
    check("refresh_done", done, 1'b1);
    run_auto("run3", sig_ref ^ 8'h01, 1'b0);

    // DONE back to IDLE.
    mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("to_idle_done", done, 1'b0);
    check("to_idle_pass", pass, 1'b0);
    check("to_idle_busy", busy, 1'b0);

    // Reset in the middle of a run.
    golden_sig = sig_ref;
    mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (69) tick();
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_pass", pass, 1'b0);
    check("mid_rst_sig", signature, 8'h00);
    repeat (3) tick();
    check("idle_hold_busy", busy, 1'b0);
    check("idle_hold_sig", signature, 8'h00);
    mode = 1'b0;
    scan_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("mid_rst_lfsr", scan_in, a[7-i]);
      tick();
    end

    run_auto("run4", sig_ref, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bist_scan_controller.md
Name: bist_scan_controller

Overview:
- Parametrised built-in self-test block: an LFSR pattern generator feeds a 2N-bit scan chain wrapped around an NxN unsigned multiplier (circuit under test, CUT); scan responses are compacted in a MISR.
- Manual mode: external scan_en drives shift and capture cycles.
- Auto mode: an internal FSM runs a fixed number of patterns and compares the final signature against a golden value.
- Sits beside the datapath as a self-contained test harness; observed by the top-level or bench through scan_in, scan_out and the result flags.

Parameters:
- N, 4: CUT operand width; chain, LFSR and MISR length L = 2N.
- NUM_PATTERNS, 16: capture cycles per auto run, >= 1.
- SEED, 8'hBD: LFSR reset/start value, L bits; must be nonzero.
- TAPS, 8'hB8: L-bit feedback mask, shared by LFSR and MISR.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- mode  in  1  0 = manual, 1 = auto; sampled only when start is accepted.
- start  in  1  auto-run request; level-sampled.
- scan_en  in  1  manual mode only: 1 = shift, 0 = capture.
- golden_sig  in  L  expected MISR value; sampled in DONE.
- scan_in  out  1  lfsr[L-1]; serial input to the chain.
- scan_out  out  1  chain[L-1].
- busy  out  1  auto run in progress.
- done  out  1  auto run finished; sticky.
- pass  out  1  signature == golden_sig; valid while done = 1.
- signature  out  L  current MISR contents.

Behaviour:
Reset (rst = 1 at an edge; takes priority over everything):
- lfsr = SEED, chain = 0, misr = 0, state = IDLE.
- busy = 0, done = 0, pass = 0.

Shift cycle:
- lfsr <= {lfsr[L-2:0], ^(lfsr & TAPS)}.
- chain <= {chain[L-2:0], lfsr[L-1]}.
- misr <= {misr[L-2:0], 1'b0} ^ (misr[L-1] ? TAPS : 0) ^ {{L-1{0}}, chain[L-1]}.
- Consequence: after L consecutive shifts from a given lfsr state S, chain == S.

Capture cycle:
- chain <= chain[L-1:N] * chain[N-1:0], full 2N-bit product, no truncation.
- lfsr and misr hold.

Manual mode (state IDLE and mode = 0):
- Every cycle is a shift if scan_en = 1, a capture if scan_en = 0.
- start is ignored.

Auto FSM (states IDLE, SHIFT, CAPTURE, UNLOAD, DONE):
- IDLE: holds all state if mode = 1 and start = 0.
- IDLE -> SHIFT on start = 1 with mode = 1. The acceptance edge reloads lfsr = SEED, chain = 0, misr = 0, and clears done and pass.
- SHIFT: L shift cycles (bit counter 0..L-1), then -> CAPTURE.
- CAPTURE: one capture cycle; pattern counter increments. Then -> SHIFT if count < NUM_PATTERNS, else -> UNLOAD.
- UNLOAD: L shift cycles, then -> DONE.
- busy = 1 exactly in SHIFT, CAPTURE and UNLOAD: NUM_PATTERNS*(L+1) + L cycles (152 at defaults).
- DONE: done = 1; pass registered as (misr == golden_sig) on DONE entry and refreshed every cycle while in DONE.
- DONE -> SHIFT on start = 1 with mode = 1 (restart, with the same clears as acceptance from IDLE).
- DONE -> IDLE on start = 1 with mode = 0; done and pass clear.

Boundary conditions:
- start while busy: ignored.
- mode or scan_en changes while busy: ignored.
- rst mid-run: immediate return to IDLE with all reset values; no partial done.
- scan_en toggling in DONE: no effect; state holds.
- Counters are sized for L and NUM_PATTERNS with no wrap inside a run.

Test Plan:
1. rst pulse; then manual mode, scan_en = 1 for 8 cycles -> scan_in sequence 1,0,1,1,1,1,0,1; chain = 8'hBD; lfsr = 8'h74.
2. Continue from scenario 1: one cycle scan_en = 0 -> chain = 8'h8F (11 * 13 = 143); the next 8 shifts present scan_out = 1,0,0,0,1,1,1,1.
3. Auto mode, one-cycle start pulse -> busy high for exactly 152 cycles, then done = 1; signature equals the bench reference-model MISR value.
4. Rerun scenario 3 with golden_sig = that signature -> pass = 1. Rerun with golden_sig bit 0 flipped -> pass = 0, done = 1.
5. Assert rst at cycle 70 of an auto run -> the next cycle shows busy = 0, done = 0, signature = 0, lfsr = 8'hBD.
6. Pulse start again during busy, and while in DONE -> no effect during busy; from DONE a fresh 152-cycle run restarts with done cleared.
